// File: rtl/score_pkg.sv
// Shared types and constants for the home-screen score tally controller.
package score_pkg;

    localparam int SCORE_W           = 7;
    localparam int DIGIT_W           = 4;
    localparam int MAX_SCORE_DEFAULT = 99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_BLINK = 2'd2
    } state_e;

    // Clamp an incoming score to the largest value two BCD digits can show.
    function automatic logic [SCORE_W-1:0] sat_score(
        input logic [SCORE_W-1:0] value,
        input int                 max_score
    );
        logic [SCORE_W-1:0] limit;
        limit = SCORE_W'(max_score);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/score_tally_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear and a binary mirror of
// the same value, so comparisons never need a BCD-to-binary conversion.
module bcd2_counter
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic [SCORE_W-1:0] bin
);

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic [SCORE_W-1:0] bin_q,  bin_d;

    // Clear has priority; the caller never increments past 99.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        bin_d  = bin_q;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
            bin_d  = '0;
        end else if (inc) begin
            bin_d = bin_q + 1'b1;
            if (ones_q == DIGIT_W'(9)) begin
                ones_d = '0;
                tens_d = tens_q + 1'b1;
            end else begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
            bin_q  <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
            bin_q  <= bin_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;
    assign bin  = bin_q;

endmodule

// File: rtl/score_tally_ctrl.sv
// Home-screen score sequencer: counts the shown score up to a new target,
// blinks it a fixed number of times, then holds it steady.
module score_tally_ctrl
    import score_pkg::*;
#(
    parameter int MAX_SCORE     = MAX_SCORE_DEFAULT,
    parameter int STEP_TICKS    = 2,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    input  logic               tick,
    output logic [DIGIT_W-1:0] disp_tens,
    output logic [DIGIT_W-1:0] disp_ones,
    output logic               show,
    output logic               busy,
    output logic               done
);

    localparam int STEP_W  = (STEP_TICKS    > 1) ? $clog2(STEP_TICKS)    : 1;
    localparam int BLINK_W = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;

    state_e             state_q,     state_d;
    logic [SCORE_W-1:0] target_q,    target_d;
    logic [STEP_W-1:0]  step_cnt_q,  step_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               show_q,      show_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;

    logic               cnt_clr;
    logic               cnt_inc;
    logic [SCORE_W-1:0] disp_bin;
    logic [SCORE_W-1:0] score_sat;

    bcd2_counter u_digits (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .tens (disp_tens),
        .ones (disp_ones),
        .bin  (disp_bin)
    );

    assign score_sat = sat_score(score_in, MAX_SCORE);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        step_cnt_d  = step_cnt_q;
        blink_cnt_d = blink_cnt_q;
        show_d      = show_q;
        done_d      = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        // A new score overrides everything else this cycle, including the
        // tick and the reached-target check.
        if (score_valid) begin
            target_d   = score_sat;
            cnt_clr    = (score_sat < disp_bin);
            step_cnt_d = '0;
            show_d     = 1'b1;
            state_d    = ST_COUNT;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (disp_bin == target_q) begin
                        state_d     = ST_BLINK;
                        done_d      = 1'b1;
                        blink_cnt_d = '0;
                    end else if (tick) begin
                        if (step_cnt_q == STEP_W'(STEP_TICKS - 1)) begin
                            cnt_inc    = 1'b1;
                            step_cnt_d = '0;
                        end else begin
                            step_cnt_d = step_cnt_q + 1'b1;
                        end
                    end
                end
                ST_BLINK: begin
                    if (tick) begin
                        if (blink_cnt_q == BLINK_W'(BLINK_TOGGLES - 1)) begin
                            state_d = ST_IDLE;
                            show_d  = 1'b1;
                        end else begin
                            show_d      = ~show_q;
                            blink_cnt_d = blink_cnt_q + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    show_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    show_d  = 1'b1;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            step_cnt_q  <= '0;
            blink_cnt_q <= '0;
            show_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            step_cnt_q  <= step_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            show_q      <= show_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign show = show_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_score_tally_ctrl.sv
// Self-checking bench for score_tally_ctrl: directed table, corner-case
// sequences and random stimulus against a behavioural score model.
module tb_score_tally_ctrl;

    localparam int MAXS  = 99;
    localparam int STEPS = 2;
    localparam int BLNK  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] score_in = '0;
    logic       score_valid = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] disp_tens;
    logic [3:0] disp_ones;
    logic       show;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    score_tally_ctrl #(
        .MAX_SCORE     (MAXS),
        .STEP_TICKS    (STEPS),
        .BLINK_TOGGLES (BLNK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .score_in    (score_in),
        .score_valid (score_valid),
        .tick        (tick),
        .disp_tens   (disp_tens),
        .disp_ones   (disp_ones),
        .show        (show),
        .busy        (busy),
        .done        (done)
    );

    // Behavioural model: displayed score as a plain integer, phase name,
    // ticks spent on the current step and toggles performed so far.
    localparam int P_IDLE = 0, P_COUNT = 1, P_BLINK = 2;
    int m_disp = 0, m_target = 0, m_phase = P_IDLE;
    int m_ticks = 0, m_toggles = 0;
    bit m_show = 1, m_done = 0;

    task automatic model_update(input bit r, input bit v, input int s, input bit t);
        int tgt;
        if (r) begin
            m_disp = 0; m_target = 0; m_phase = P_IDLE;
            m_ticks = 0; m_toggles = 0; m_show = 1; m_done = 0;
            return;
        end
        m_done = 0;
        if (v) begin
            tgt = (s > MAXS) ? MAXS : s;
            if (tgt < m_disp) m_disp = 0;
            m_target = tgt;
            m_ticks  = 0;
            m_show   = 1;
            m_phase  = P_COUNT;
        end else if (m_phase == P_COUNT) begin
            if (m_disp == m_target) begin
                m_phase = P_BLINK; m_done = 1; m_toggles = 0;
            end else if (t) begin
                m_ticks++;
                if (m_ticks == STEPS) begin
                    m_disp++;
                    m_ticks = 0;
                end
            end
        end else if (m_phase == P_BLINK && t) begin
            m_toggles++;
            if (m_toggles == BLNK) begin
                m_phase = P_IDLE;
                m_show  = 1;
            end else begin
                m_show = !m_show;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        check("tens",  int'(disp_tens), m_disp / 10);
        check("ones",  int'(disp_ones), m_disp % 10);
        check("show",  int'(show), int'(m_show));
        check("busy",  int'(busy), (m_phase != P_IDLE) ? 1 : 0);
        check("done",  int'(done), int'(m_done));
    endtask

    task automatic step(input bit r, input bit v, input int s, input bit t);
        rst = r; score_valid = v; score_in = 7'(s); tick = t;
        @(posedge clk);
        model_update(r, v, s, t);
        #1;
        compare_model();
    endtask

    // Ticks continuously until the model returns to idle, bounded by budget.
    task automatic run_to_idle(input int budget, input string name);
        int n;
        n = 0;
        while (m_phase != P_IDLE && n < budget) begin
            step(0, 0, 0, 1);
            n++;
        end
        check({name, "_timeout"}, (n < budget) ? 1 : 0, 1);
    endtask

    typedef struct {
        bit r, v; int s; bit t;
        int e_tens, e_ones; bit e_show, e_busy, e_done;
    } vec_t;

    vec_t vecs[15];
    int   done_cnt, max_seen, cur;

    initial begin
        vecs[0]  = '{1,0,0,0, 0,0,1,0,0};
        vecs[1]  = '{0,1,1,0, 0,0,1,1,0};
        vecs[2]  = '{0,0,0,1, 0,0,1,1,0};
        vecs[3]  = '{0,0,0,1, 0,1,1,1,0};
        vecs[4]  = '{0,0,0,0, 0,1,1,1,1};
        vecs[5]  = '{0,0,0,0, 0,1,1,1,0};
        vecs[6]  = '{0,0,0,1, 0,1,0,1,0};
        vecs[7]  = '{0,1,0,1, 0,0,1,1,0};
        vecs[8]  = '{0,0,0,0, 0,0,1,1,1};
        vecs[9]  = '{0,1,2,1, 0,0,1,1,0};
        vecs[10] = '{0,0,0,1, 0,0,1,1,0};
        vecs[11] = '{0,0,0,1, 0,1,1,1,0};
        vecs[12] = '{0,0,0,1, 0,1,1,1,0};
        vecs[13] = '{1,0,0,1, 0,0,1,0,0};
        vecs[14] = '{0,0,0,1, 0,0,1,0,0};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].t);
            check("tbl_tens", int'(disp_tens), vecs[i].e_tens);
            check("tbl_ones", int'(disp_ones), vecs[i].e_ones);
            check("tbl_show", int'(show), int'(vecs[i].e_show));
            check("tbl_busy", int'(busy), int'(vecs[i].e_busy));
            check("tbl_done", int'(done), int'(vecs[i].e_done));
            $display("vec %0d: rst=%0d sv=%0d score=%0d tick=%0d -> %0d%0d show=%0d busy=%0d done=%0d",
                     i, vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].t,
                     disp_tens, disp_ones, show, busy, done);
        end

        // Count to 12 with continuous ticks, then a full blink phase.
        step(0, 1, 12, 0);
        done_cnt = 0;
        for (int n = 0; n < 80 && m_phase != P_IDLE; n++) begin
            step(0, 0, 0, 1);
            if (done) begin
                done_cnt++;
                check("d12_val", int'(disp_tens) * 10 + int'(disp_ones), 12);
            end
        end
        check("d12_done_once", done_cnt, 1);
        check("d12_idle_show", int'(show), 1);
        $display("seq count12: display=%0d%0d done_pulses=%0d", disp_tens, disp_ones, done_cnt);

        // Tens carry: 09 -> 10 in a single increment.
        step(0, 1, 9, 0);
        run_to_idle(80, "to09");
        step(0, 1, 10, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("carry_tens", int'(disp_tens), 1);
        check("carry_ones", int'(disp_ones), 0);
        run_to_idle(40, "to10");
        $display("seq carry: display=%0d%0d", disp_tens, disp_ones);

        // Saturation: 120 latches as 99, display never wraps.
        step(0, 1, 120, 0);
        done_cnt = 0; max_seen = 0;
        for (int n = 0; n < 260 && m_phase != P_IDLE; n++) begin
            step(0, 0, 0, 1);
            cur = int'(disp_tens) * 10 + int'(disp_ones);
            if (cur > max_seen) max_seen = cur;
            if (done) begin
                done_cnt++;
                check("sat_done_at", cur, 99);
            end
        end
        check("sat_max", max_seen, 99);
        check("sat_done_once", done_cnt, 1);
        $display("seq saturate: max=%0d done_pulses=%0d", max_seen, done_cnt);

        // Lower target clears digits on the strobe edge.
        step(0, 1, 45, 0);
        run_to_idle(140, "to45");
        check("at45", int'(disp_tens) * 10 + int'(disp_ones), 45);
        step(0, 1, 30, 0);
        check("clr_tens", int'(disp_tens), 0);
        check("clr_ones", int'(disp_ones), 0);
        run_to_idle(100, "to30");
        check("at30", int'(disp_tens) * 10 + int'(disp_ones), 30);
        $display("seq clear: display=%0d%0d", disp_tens, disp_ones);

        // Reset mid-count at 07.
        step(0, 1, 20, 0);
        for (int n = 0; n < 14; n++) step(0, 0, 0, 1);
        check("pre_rst_07", int'(disp_tens) * 10 + int'(disp_ones), 7);
        step(1, 0, 0, 1);
        check("rst_disp", int'(disp_tens) * 10 + int'(disp_ones), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        for (int n = 0; n < 5; n++) step(0, 0, 0, 1);
        check("rst_hold", int'(disp_tens) * 10 + int'(disp_ones), 0);
        $display("seq reset: display=%0d%0d busy=%0d", disp_tens, disp_ones, busy);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit r, v, t;
            int s;
            r = ($urandom_range(0, 599) == 0);
            v = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(95, 127))
                                              : int'($urandom_range(0, 127));
            t = 1'($urandom_range(0, 1));
            step(r, v, s, t);
            if (v && !r)
                $display("rand %0d: score=%0d -> display=%0d%0d busy=%0d", n, s, disp_tens, disp_ones, busy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
